// File: rtl/framebuffer_stream_dma_writer.sv
// rtl/framebuffer_stream_dma_writer.sv - AXIS frame-tile stream to AXI4 INCR burst writer
//
// Purpose: accepts one committed frame-tile stream, buffers up to BURST_LEN
// beats so the burst length is known up front, then writes each chunk as one
// AXI4 INCR burst starting at a programmable base address. The final burst
// carries only the beats that remain.
//
// Optional feature macro: FRAMEBUFFER_STREAM_DMA_WRITER_RESP_CHECK_EN
//   defined     - a non-OKAY bresp sets sticky error, the rest of the stream is
//                 discarded and no further bursts are issued.
//   not defined - bresp is ignored and error is held at 0.
//
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   cmdStart, cmdBaseAddr      start pulse and destination byte address
//   busy, done, error          status: in progress, completion pulse, sticky resp error
//   s_axis_*                   input stream (tvalid/tready/tlast/tdata)
//   m_axi_aw*                  write address channel
//   m_axi_w*                   write data channel
//   m_axi_b*                   write response channel
module framebuffer_stream_dma_writer #(
    parameter int STREAM_WIDTH = 32,
    parameter int ADDR_WIDTH   = 32,
    parameter int BURST_LEN    = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      cmdStart,
    input  logic [ADDR_WIDTH-1:0]     cmdBaseAddr,
    output logic                      busy,
    output logic                      done,
    output logic                      error,
    input  logic                      s_axis_tvalid,
    output logic                      s_axis_tready,
    input  logic                      s_axis_tlast,
    input  logic [STREAM_WIDTH-1:0]   s_axis_tdata,
    output logic                      m_axi_awvalid,
    input  logic                      m_axi_awready,
    output logic [ADDR_WIDTH-1:0]     m_axi_awaddr,
    output logic [7:0]                m_axi_awlen,
    output logic [2:0]                m_axi_awsize,
    output logic [1:0]                m_axi_awburst,
    output logic                      m_axi_wvalid,
    input  logic                      m_axi_wready,
    output logic [STREAM_WIDTH-1:0]   m_axi_wdata,
    output logic [STREAM_WIDTH/8-1:0] m_axi_wstrb,
    output logic                      m_axi_wlast,
    input  logic                      m_axi_bvalid,
    output logic                      m_axi_bready,
    input  logic [1:0]                m_axi_bresp
);

    localparam int BYTES = STREAM_WIDTH / 8;
    localparam int SHIFT = $clog2(BYTES);
    // count must reach BURST_LEN itself, so it needs one bit more than an index
    localparam int CW    = $clog2(BURST_LEN) + 1;
    localparam int IW    = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FILL,
        S_ADDR,
        S_DATA,
        S_RESP,
        S_SKIP
    } state_t;

    state_t                  state_q;
    logic [CW-1:0]           count_q;
    logic [IW-1:0]           rd_idx_q;
    logic                    frame_last_q;
    logic [ADDR_WIDTH-1:0]   cur_addr_q;
    logic                    busy_q;
    logic                    done_q;
    logic                    error_q;
    logic                    tready_q;
    logic                    awvalid_q;
    logic [ADDR_WIDTH-1:0]   awaddr_q;
    logic [7:0]              awlen_q;
    logic                    wvalid_q;
    logic [STREAM_WIDTH-1:0] wdata_q;
    logic                    wlast_q;
    logic                    bready_q;

    logic [STREAM_WIDTH-1:0] mem_q [BURST_LEN];

    logic                    beat_fire_d;
    logic [CW-1:0]           count_inc_d;
    logic [CW-1:0]           last_idx_d;
    logic [ADDR_WIDTH-1:0]   next_addr_d;
    logic                    resp_bad_d;

    assign beat_fire_d = s_axis_tvalid & tready_q;
    assign count_inc_d = count_q + CW'(1);
    assign last_idx_d  = count_q - CW'(1);
    assign next_addr_d = cur_addr_q + (ADDR_WIDTH'(count_q) << SHIFT);

`ifdef FRAMEBUFFER_STREAM_DMA_WRITER_RESP_CHECK_EN
    assign resp_bad_d = m_axi_bresp != 2'b00;
`else
    logic unused_bresp;
    assign unused_bresp = ^m_axi_bresp;
    assign resp_bad_d   = 1'b0;
`endif

    // Burst buffer: no reset needed, contents are only read after being written
    always_ff @(posedge clk) begin
        if (state_q == S_FILL && beat_fire_d) begin
            mem_q[count_q[IW-1:0]] <= s_axis_tdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            count_q      <= '0;
            rd_idx_q     <= '0;
            frame_last_q <= 1'b0;
            cur_addr_q   <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
            tready_q     <= 1'b0;
            awvalid_q    <= 1'b0;
            awaddr_q     <= '0;
            awlen_q      <= '0;
            wvalid_q     <= 1'b0;
            wdata_q      <= '0;
            wlast_q      <= 1'b0;
            bready_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (cmdStart) begin
                        cur_addr_q   <= cmdBaseAddr;
                        error_q      <= 1'b0;
                        busy_q       <= 1'b1;
                        count_q      <= '0;
                        frame_last_q <= 1'b0;
                        tready_q     <= 1'b1;
                        state_q      <= S_FILL;
                    end
                end
                S_FILL: begin
                    if (beat_fire_d) begin
                        count_q <= count_inc_d;
                        // Close the burst on tlast or when the buffer is full;
                        // awlen is the pre-increment count (beats - 1).
                        if (s_axis_tlast || count_inc_d == CW'(BURST_LEN)) begin
                            tready_q     <= 1'b0;
                            frame_last_q <= s_axis_tlast;
                            awvalid_q    <= 1'b1;
                            awaddr_q     <= cur_addr_q;
                            awlen_q      <= 8'(count_q);
                            state_q      <= S_ADDR;
                        end
                    end
                end
                S_ADDR: begin
                    if (m_axi_awready) begin
                        awvalid_q <= 1'b0;
                        wvalid_q  <= 1'b1;
                        wdata_q   <= mem_q[0];
                        wlast_q   <= (count_q == CW'(1));
                        // rd_idx points at the beat to present after the next handshake
                        rd_idx_q  <= IW'(1);
                        state_q   <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (m_axi_wready) begin
                        if (wlast_q) begin
                            wvalid_q <= 1'b0;
                            wlast_q  <= 1'b0;
                            bready_q <= 1'b1;
                            state_q  <= S_RESP;
                        end else begin
                            wdata_q  <= mem_q[rd_idx_q];
                            wlast_q  <= (CW'(rd_idx_q) == last_idx_d);
                            rd_idx_q <= rd_idx_q + IW'(1);
                        end
                    end
                end
                S_RESP: begin
                    if (m_axi_bvalid) begin
                        bready_q <= 1'b0;
                        if (resp_bad_d) begin
                            error_q <= 1'b1;
                            if (frame_last_q) begin
                                done_q  <= 1'b1;
                                busy_q  <= 1'b0;
                                state_q <= S_IDLE;
                            end else begin
                                tready_q <= 1'b1;
                                state_q  <= S_SKIP;
                            end
                        end else if (frame_last_q) begin
                            done_q  <= 1'b1;
                            busy_q  <= 1'b0;
                            state_q <= S_IDLE;
                        end else begin
                            cur_addr_q <= next_addr_d;
                            count_q    <= '0;
                            tready_q   <= 1'b1;
                            state_q    <= S_FILL;
                        end
                    end
                end
                S_SKIP: begin
                    // Swallow the rest of the stream after a failed burst
                    if (beat_fire_d && s_axis_tlast) begin
                        tready_q <= 1'b0;
                        done_q   <= 1'b1;
                        busy_q   <= 1'b0;
                        state_q  <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign busy          = busy_q;
    assign done          = done_q;
    assign error         = error_q;
    assign s_axis_tready = tready_q;
    assign m_axi_awvalid = awvalid_q;
    assign m_axi_awaddr  = awaddr_q;
    assign m_axi_awlen   = awlen_q;
    assign m_axi_awsize  = 3'(SHIFT);
    assign m_axi_awburst = 2'b01;
    assign m_axi_wvalid  = wvalid_q;
    assign m_axi_wdata   = wdata_q;
    assign m_axi_wstrb   = '1;
    assign m_axi_wlast   = wlast_q;
    assign m_axi_bready  = bready_q;

endmodule

// File: tb/tb_framebuffer_stream_dma_writer.sv
// tb/tb_framebuffer_stream_dma_writer.sv - directed bench for framebuffer_stream_dma_writer
module tb_framebuffer_stream_dma_writer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cmdStart = 1'b0;
    logic [31:0] cmdBaseAddr = '0;
    logic        busy, done, error;
    logic        s_axis_tvalid = 1'b0;
    logic        s_axis_tready;
    logic        s_axis_tlast = 1'b0;
    logic [31:0] s_axis_tdata = '0;
    logic        m_axi_awvalid;
    logic        m_axi_awready = 1'b0;
    logic [31:0] m_axi_awaddr;
    logic [7:0]  m_axi_awlen;
    logic [2:0]  m_axi_awsize;
    logic [1:0]  m_axi_awburst;
    logic        m_axi_wvalid;
    logic        m_axi_wready = 1'b0;
    logic [31:0] m_axi_wdata;
    logic [3:0]  m_axi_wstrb;
    logic        m_axi_wlast;
    logic        m_axi_bvalid = 1'b0;
    logic        m_axi_bready;
    logic [1:0]  m_axi_bresp = 2'b00;

    always #5 clk = ~clk;

    framebuffer_stream_dma_writer #(
        .STREAM_WIDTH(32),
        .ADDR_WIDTH  (32),
        .BURST_LEN   (16)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .cmdStart     (cmdStart),
        .cmdBaseAddr  (cmdBaseAddr),
        .busy         (busy),
        .done         (done),
        .error        (error),
        .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tready(s_axis_tready),
        .s_axis_tlast (s_axis_tlast),
        .s_axis_tdata (s_axis_tdata),
        .m_axi_awvalid(m_axi_awvalid),
        .m_axi_awready(m_axi_awready),
        .m_axi_awaddr (m_axi_awaddr),
        .m_axi_awlen  (m_axi_awlen),
        .m_axi_awsize (m_axi_awsize),
        .m_axi_awburst(m_axi_awburst),
        .m_axi_wvalid (m_axi_wvalid),
        .m_axi_wready (m_axi_wready),
        .m_axi_wdata  (m_axi_wdata),
        .m_axi_wstrb  (m_axi_wstrb),
        .m_axi_wlast  (m_axi_wlast),
        .m_axi_bvalid (m_axi_bvalid),
        .m_axi_bready (m_axi_bready),
        .m_axi_bresp  (m_axi_bresp)
    );

    int checks = 0;
    int failures = 0;

    // Memory-side model state
    logic        stall_en = 1'b0;
    logic        bresp_err_first = 1'b0;
    logic [31:0] aw_addr_q[$];
    logic [7:0]  aw_len_q[$];
    logic [31:0] mem_img [logic [31:0]];
    logic [31:0] wptr = '0;
    int          cur_len = 0, beat = 0;
    int          n_done = 0, done_busy_err = 0, n_wlast = 0, wlast_err = 0;
    int          n_b = 0, b_pending = 0, stab_err = 0, stab_cnt = 0, tready_err = 0;
    logic        b_fired = 1'b0, aw_stall_prev = 1'b0, w_stall_prev = 1'b0;
    logic [31:0] prev_awaddr = '0, prev_wdata = '0;
    logic [7:0]  prev_awlen = '0;
    logic        prev_wlast = 1'b0;

    function automatic logic [31:0] data_of(input int seed, input int i);
        return {8'hA5, 8'(seed), 16'(i)};
    endfunction

    function automatic int mem_bad(input logic [31:0] base, input int n, input int seed);
        int bad = 0;
        for (int i = 0; i < n; i++) begin
            logic [31:0] a;
            a = base + 32'(4 * i);
            if (!mem_img.exists(a)) bad++;
            else if (mem_img[a] !== data_of(seed, i)) bad++;
        end
        return bad;
    endfunction

    // Slave model: inputs change on negedge, handshakes resolve at next posedge
    always @(negedge clk) begin
        if (done) begin
            n_done++;
            if (busy) done_busy_err++;
        end
        if (reset) begin
            m_axi_awready = 1'b0;
            m_axi_wready  = 1'b0;
            m_axi_bvalid  = 1'b0;
            m_axi_bresp   = 2'b00;
            b_pending = 0; beat = 0; b_fired = 1'b0;
            aw_stall_prev = 1'b0; w_stall_prev = 1'b0;
        end else begin
            if (aw_stall_prev) begin
                stab_cnt++;
                if (!m_axi_awvalid || m_axi_awaddr !== prev_awaddr || m_axi_awlen !== prev_awlen) stab_err++;
            end
            if (w_stall_prev) begin
                stab_cnt++;
                if (!m_axi_wvalid || m_axi_wdata !== prev_wdata || m_axi_wlast !== prev_wlast) stab_err++;
            end
            if (s_axis_tready && (m_axi_awvalid || m_axi_wvalid || m_axi_bready)) tready_err++;

            if (b_fired) begin
                m_axi_bvalid = 1'b0;
                b_fired = 1'b0;
            end
            if (!m_axi_bvalid) begin
                m_axi_bvalid = (b_pending > 0) && (!stall_en || $urandom_range(0, 2) == 0);
                m_axi_bresp  = (bresp_err_first && n_b == 0) ? 2'b10 : 2'b00;
            end
            if (m_axi_bvalid && m_axi_bready) begin
                b_pending--; n_b++; b_fired = 1'b1;
            end

            m_axi_awready = !stall_en || ($urandom_range(0, 2) != 0);
            if (m_axi_awvalid && m_axi_awready) begin
                aw_addr_q.push_back(m_axi_awaddr);
                aw_len_q.push_back(m_axi_awlen);
                wptr = m_axi_awaddr; cur_len = int'(m_axi_awlen); beat = 0;
            end
            aw_stall_prev = m_axi_awvalid && !m_axi_awready;
            prev_awaddr = m_axi_awaddr; prev_awlen = m_axi_awlen;

            m_axi_wready = !stall_en || ($urandom_range(0, 2) != 0);
            if (m_axi_wvalid && m_axi_wready) begin
                mem_img[wptr] = m_axi_wdata;
                wptr = wptr + 32'd4;
                if (m_axi_wlast !== (beat == cur_len)) wlast_err++;
                if (m_axi_wlast) begin
                    n_wlast++; b_pending++; beat = 0;
                end else begin
                    beat++;
                end
            end
            w_stall_prev = m_axi_wvalid && !m_axi_wready;
            prev_wdata = m_axi_wdata; prev_wlast = m_axi_wlast;
        end
    end

    task automatic clear_model();
        @(posedge clk); #1;
        aw_addr_q.delete(); aw_len_q.delete(); mem_img.delete();
        n_done = 0; done_busy_err = 0; n_wlast = 0; wlast_err = 0; n_b = 0;
        stab_err = 0; stab_cnt = 0; tready_err = 0;
    endtask

    task automatic start_cmd(input logic [31:0] base);
        @(negedge clk); cmdStart = 1'b1; cmdBaseAddr = base;
        @(negedge clk); cmdStart = 1'b0;
    endtask

    task automatic drive_stream(input int n, input bit gaps, input int seed, output int sent);
        int guard = 0;
        sent = 0;
        while (sent < n && guard < 5000) begin
            @(negedge clk); guard++;
            s_axis_tvalid = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
            s_axis_tdata  = data_of(seed, sent);
            s_axis_tlast  = (sent == n - 1);
            if (s_axis_tvalid && s_axis_tready) sent++;
        end
        @(negedge clk);
        s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
    endtask

    task automatic wait_done(input int exp, input int budget, input string name);
        int cyc = 0;
        while (n_done < exp && cyc < budget) begin
            @(negedge clk); cyc++;
        end
        checks++;
        if (n_done < exp) begin
            failures++;
            $display("FAIL %s_done_timeout: done count %0d after %0d cycles, required %0d", name, n_done, cyc, exp);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({busy, done, error} !== 3'b000) begin
            failures++; $display("FAIL reset_status: busy/done/error=%b required 000", {busy, done, error});
        end
        checks++;
        if ({s_axis_tready, m_axi_awvalid, m_axi_wvalid, m_axi_wlast, m_axi_bready} !== 5'b0) begin
            failures++; $display("FAIL reset_handshakes: tready/awvalid/wvalid/wlast/bready=%b required 00000",
                {s_axis_tready, m_axi_awvalid, m_axi_wvalid, m_axi_wlast, m_axi_bready});
        end
        checks++;
        if (m_axi_awaddr !== 32'h0 || m_axi_awlen !== 8'h0) begin
            failures++; $display("FAIL reset_aw_fields: awaddr=%h awlen=%0d required 0/0", m_axi_awaddr, m_axi_awlen);
        end
        checks++;
        if (m_axi_awsize !== 3'd2 || m_axi_awburst !== 2'b01 || m_axi_wstrb !== 4'hF) begin
            failures++; $display("FAIL const_fields: awsize=%0d awburst=%b wstrb=%h required 2/01/f",
                m_axi_awsize, m_axi_awburst, m_axi_wstrb);
        end
        reset = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || s_axis_tready !== 1'b0) begin
            failures++; $display("FAIL idle_after_reset: busy=%b tready=%b required 0/0", busy, s_axis_tready);
        end
    endtask

    task automatic test_multi_burst();
        int sent;
        clear_model();
        start_cmd(32'h1000);
        checks++;
        if (busy !== 1'b1) begin
            failures++; $display("FAIL multi_busy_after_start: busy=%b required 1", busy);
        end
        drive_stream(40, 1'b0, 1, sent);
        wait_done(1, 500, "multi");
        checks++;
        if (aw_addr_q.size() != 3 || aw_addr_q[0] !== 32'h1000 || aw_addr_q[1] !== 32'h1040 || aw_addr_q[2] !== 32'h1080) begin
            failures++; $display("FAIL multi_aw_addr: %0d bursts, addrs %p, required 1000/1040/1080", aw_addr_q.size(), aw_addr_q);
        end
        checks++;
        if (aw_len_q.size() != 3 || aw_len_q[0] !== 8'd15 || aw_len_q[1] !== 8'd15 || aw_len_q[2] !== 8'd7) begin
            failures++; $display("FAIL multi_aw_len: lens %p, required 15/15/7", aw_len_q);
        end
        checks++;
        if (sent != 40 || mem_bad(32'h1000, 40, 1) != 0) begin
            failures++; $display("FAIL multi_mem_image: sent=%0d bad words=%0d, required 40/0", sent, mem_bad(32'h1000, 40, 1));
        end
        checks++;
        if (n_wlast != 3 || wlast_err != 0) begin
            failures++; $display("FAIL multi_wlast: wlast count=%0d misplaced=%0d, required 3/0", n_wlast, wlast_err);
        end
        repeat (20) @(negedge clk);
        checks++;
        if (n_done != 1 || done_busy_err != 0 || busy !== 1'b0) begin
            failures++; $display("FAIL multi_done_pulse: done count=%0d busy-at-done=%0d busy=%b, required 1/0/0",
                n_done, done_busy_err, busy);
        end
    endtask

    task automatic test_exact_boundary();
        int sent;
        clear_model();
        start_cmd(32'h3000);
        drive_stream(16, 1'b0, 2, sent);
        wait_done(1, 300, "boundary");
        repeat (20) @(negedge clk);
        checks++;
        if (aw_addr_q.size() != 1 || aw_addr_q[0] !== 32'h3000 || aw_len_q[0] !== 8'd15) begin
            failures++; $display("FAIL boundary_single_burst: %0d bursts addrs %p lens %p, required 1 at 3000 len 15",
                aw_addr_q.size(), aw_addr_q, aw_len_q);
        end
        checks++;
        if (n_wlast != 1 || wlast_err != 0 || mem_bad(32'h3000, 16, 2) != 0) begin
            failures++; $display("FAIL boundary_data: wlast=%0d misplaced=%0d bad words=%0d, required 1/0/0",
                n_wlast, wlast_err, mem_bad(32'h3000, 16, 2));
        end
    endtask

    task automatic test_single_beat();
        int sent;
        clear_model();
        start_cmd(32'h2000);
        drive_stream(1, 1'b0, 3, sent);
        wait_done(1, 200, "single");
        checks++;
        if (aw_addr_q.size() != 1 || aw_addr_q[0] !== 32'h2000 || aw_len_q[0] !== 8'd0) begin
            failures++; $display("FAIL single_aw: %0d bursts addrs %p lens %p, required 1 at 2000 len 0",
                aw_addr_q.size(), aw_addr_q, aw_len_q);
        end
        checks++;
        if (n_wlast != 1 || wlast_err != 0 || mem_bad(32'h2000, 1, 3) != 0) begin
            failures++; $display("FAIL single_data: wlast=%0d misplaced=%0d bad words=%0d, required 1/0/0",
                n_wlast, wlast_err, mem_bad(32'h2000, 1, 3));
        end
    endtask

    task automatic test_stalls();
        int sent;
        clear_model();
        stall_en = 1'b1;
        start_cmd(32'h4000);
        drive_stream(37, 1'b1, 4, sent);
        wait_done(1, 3000, "stall");
        stall_en = 1'b0;
        repeat (5) @(negedge clk);
        checks++;
        if (aw_addr_q.size() != 3 || aw_addr_q[0] !== 32'h4000 || aw_addr_q[1] !== 32'h4040 || aw_addr_q[2] !== 32'h4080
            || aw_len_q[0] !== 8'd15 || aw_len_q[1] !== 8'd15 || aw_len_q[2] !== 8'd4) begin
            failures++; $display("FAIL stall_aw: addrs %p lens %p, required 4000/4040/4080 lens 15/15/4", aw_addr_q, aw_len_q);
        end
        checks++;
        if (sent != 37 || mem_bad(32'h4000, 37, 4) != 0 || wlast_err != 0) begin
            failures++; $display("FAIL stall_mem_image: sent=%0d bad words=%0d wlast misplaced=%0d, required 37/0/0",
                sent, mem_bad(32'h4000, 37, 4), wlast_err);
        end
        checks++;
        if (stab_err != 0 || stab_cnt == 0) begin
            failures++; $display("FAIL stall_stability: unstable cycles=%0d of %0d stalled, required 0 of >0", stab_err, stab_cnt);
        end
        checks++;
        if (tready_err != 0) begin
            failures++; $display("FAIL stall_tready_outside_fill: %0d cycles, required 0", tready_err);
        end
    endtask

    task automatic test_cmd_while_busy();
        int sent;
        clear_model();
        start_cmd(32'h5000);
        fork
            drive_stream(20, 1'b0, 5, sent);
            begin
                repeat (5) @(negedge clk);
                cmdStart = 1'b1; cmdBaseAddr = 32'h9000;
                @(negedge clk);
                cmdStart = 1'b0;
            end
        join
        wait_done(1, 400, "busy_cmd");
        repeat (20) @(negedge clk);
        checks++;
        if (aw_addr_q.size() != 2 || aw_addr_q[0] !== 32'h5000 || aw_addr_q[1] !== 32'h5040
            || aw_len_q[0] !== 8'd15 || aw_len_q[1] !== 8'd3) begin
            failures++; $display("FAIL busy_cmd_aw: addrs %p lens %p, required 5000/5040 lens 15/3", aw_addr_q, aw_len_q);
        end
        checks++;
        if (n_done != 1 || busy !== 1'b0 || mem_bad(32'h5000, 20, 5) != 0) begin
            failures++; $display("FAIL busy_cmd_done: done count=%0d busy=%b bad words=%0d, required 1/0/0",
                n_done, busy, mem_bad(32'h5000, 20, 5));
        end
    endtask

    task automatic test_reset_in_data();
        int sent, cyc, aw_before;
        clear_model();
        start_cmd(32'h6000);
        drive_stream(16, 1'b0, 6, sent);
        cyc = 0;
        while (!m_axi_wvalid && cyc < 50) begin
            @(negedge clk); cyc++;
        end
        checks++;
        if (m_axi_wvalid !== 1'b1) begin
            failures++; $display("FAIL rst_data_reach: wvalid=%b after %0d cycles, required 1", m_axi_wvalid, cyc);
        end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if ({m_axi_awvalid, m_axi_wvalid, m_axi_bready, busy, s_axis_tready} !== 5'b0) begin
            failures++; $display("FAIL rst_data_outputs: awvalid/wvalid/bready/busy/tready=%b required 00000",
                {m_axi_awvalid, m_axi_wvalid, m_axi_bready, busy, s_axis_tready});
        end
        aw_before = aw_addr_q.size();
        reset = 1'b0;
        repeat (30) @(negedge clk);
        checks++;
        if (aw_addr_q.size() != aw_before || n_done != 0 || busy !== 1'b0 || m_axi_awvalid !== 1'b0 || m_axi_wvalid !== 1'b0) begin
            failures++; $display("FAIL rst_data_quiet: aw %0d->%0d done=%0d busy=%b awvalid=%b wvalid=%b, required no change/0/0/0/0",
                aw_before, aw_addr_q.size(), n_done, busy, m_axi_awvalid, m_axi_wvalid);
        end
    endtask

`ifdef FRAMEBUFFER_STREAM_DMA_WRITER_RESP_CHECK_EN
    task automatic test_resp_error();
        int sent;
        clear_model();
        bresp_err_first = 1'b1;
        start_cmd(32'h7000);
        drive_stream(40, 1'b0, 7, sent);
        wait_done(1, 600, "resp_err");
        repeat (20) @(negedge clk);
        bresp_err_first = 1'b0;
        checks++;
        if (error !== 1'b1 || aw_addr_q.size() != 1 || sent != 40) begin
            failures++; $display("FAIL resp_err_skip: error=%b bursts=%0d beats consumed=%0d, required 1/1/40",
                error, aw_addr_q.size(), sent);
        end
        checks++;
        if (n_done != 1 || busy !== 1'b0) begin
            failures++; $display("FAIL resp_err_done: done count=%0d busy=%b, required 1/0", n_done, busy);
        end
        start_cmd(32'h8000);
        checks++;
        if (error !== 1'b0 || busy !== 1'b1) begin
            failures++; $display("FAIL resp_err_clear: error=%b busy=%b after new start, required 0/1", error, busy);
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask
`else
    task automatic test_resp_ignored();
        int sent;
        clear_model();
        bresp_err_first = 1'b1;
        start_cmd(32'hA000);
        drive_stream(40, 1'b0, 8, sent);
        wait_done(1, 600, "resp_ign");
        bresp_err_first = 1'b0;
        checks++;
        if (error !== 1'b0 || aw_addr_q.size() != 3 || mem_bad(32'hA000, 40, 8) != 0) begin
            failures++; $display("FAIL resp_ignored: error=%b bursts=%0d bad words=%0d, required 0/3/0",
                error, aw_addr_q.size(), mem_bad(32'hA000, 40, 8));
        end
    endtask
`endif

    initial begin
        test_reset();
        test_multi_burst();
        test_exact_boundary();
        test_single_beat();
        test_stalls();
        test_cmd_while_busy();
        test_reset_in_data();
`ifdef FRAMEBUFFER_STREAM_DMA_WRITER_RESP_CHECK_EN
        test_resp_error();
`else
        test_resp_ignored();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
